pipe_adder: RTL
===============

# pipe_adder

Parametrised, pipelined add/subtract unit that splits a WIDTH-bit carry chain into STAGES equal slices, one registered slice per stage. It accepts one operation per cycle under a valid/ready handshake with full back-pressure. It returns sum, carry-out and signed overflow after a fixed latency. It is the standard arithmetic building block for datapaths whose single-cycle carry chain no longer meets timing.

## Interface
- WIDTH, 32, operand and result width in bits
- STAGES, 4, number of pipeline stages and carry-chain slices; 1 ≤ STAGES ≤ WIDTH, WIDTH % STAGES == 0 (elaboration error otherwise)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid & in_ready
- a  in  WIDTH  operand A (unsigned or two's complement)
- b  in  WIDTH  operand B
- cin  in  1  carry-in (ADD) / borrow-in (SUB)
- sub  in  1  0 = ADD, 1 = SUB
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- sum  out  WIDTH  result
- cout  out  1  carry-out of MSB (SUB: 1 = no borrow)
- ovf  out  1  signed overflow

## Operation
- ADD: {cout,sum} = a + b + cin. SUB: {cout,sum} = a + ~b + !cin, i.e. a − b − cin.
- ovf = carry into MSB XOR carry out of MSB.
- SLICE = WIDTH/STAGES. Stage k (0..STAGES−1) adds bits [k*SLICE +: SLICE] using the carry registered by stage k−1; stage 0 uses the effective carry-in.
- Operand skew: slice k operands (b already inverted for SUB) are delayed k register stages before use. Result deskew: slice k's sum bits are delayed STAGES−1−k stages so that all bits of one operation leave together.
- Each stage holds a valid bit; the valid chain moves in lockstep with data.
- Global stall: advance = !out_valid | out_ready. When advance is 0, every pipeline register holds. in_ready = advance, which is combinational from out_ready.
- No bubble collapsing. Empty stages travel as valid = 0.
- Results leave in acceptance order. None are dropped or duplicated.

## Timing
- Latency: an operation accepted at edge N appears with out_valid = 1 after edge N+STAGES−1, so it is sampleable at edge N+STAGES when there is no stall. Each stall cycle adds one cycle.
- Throughput: 1 operation/cycle while out_ready = 1.
- STAGES = 1: a single registered full-width add with latency 1.
- Reset (asynchronous assert, synchronous release) clears all valid bits, sum, cout, ovf, and every internal data and carry register to 0. out_valid = 0 during reset and on the first cycle after it. A reset mid-stream discards all in-flight operations.
- With the pipeline full and out_ready = 0: in_ready = 0, and out_valid/sum/cout/ovf remain stable until the result is consumed.
- When out_ready rises while in_valid = 1, the output is consumed and the new input is accepted on the same edge.
- Wrap-around is modular: sum keeps only the low WIDTH bits, and the dropped bit appears on cout.

## Structure
- Package pipe_adder_pkg: op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1, plus default WIDTH/STAGES localparams shared by instantiating blocks.
- Sub-module adder_slice (parameter W): combinational W-bit ripple add that outputs sum, carry-out and carry-into-MSB. It is instantiated STAGES times with a generate loop. The top level contains only registers, skew/deskew, and handshake logic.

## Test plan
- WIDTH=8, STAGES=4, ADD, a=0xFF, b=0x01, cin=0, out_ready=1: out_valid after 4 edges with sum=0x00, cout=1, ovf=0.
- ADD, a=0x7F, b=0x01, cin=0: sum=0x80, cout=0, ovf=1. SUB, a=0x05, b=0x07, cin=0: sum=0xFE, cout=0, ovf=0. SUB, a=0x80, b=0x01: sum=0x7F, cout=1, ovf=1.
- Back-to-back stream of 10 ADDs (a=i, b=2i); hold out_ready=0 for 3 cycles mid-stream: in_ready=0 throughout the stall, the held result is stable, and all 10 results (3i) arrive in order with no gaps after release.
- Assert rst for 1 cycle with 3 operations in flight: out_valid=0 and sum=cout=ovf=0 immediately, and none of the discarded operations ever appears; an operation issued after reset returns the correct result at latency 4.
- Randomised, 10k operations per config, with random in_valid/out_ready against a reference model, for (WIDTH,STAGES) = (32,1), (32,4), (32,32), (8,2). Check exact match of sum/cout/ovf and ordering, and verify that throughput reaches 1/cycle when out_ready=1.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared constants for the pipelined add/subtract unit and its users.
package pipe_adder_pkg;

    // Operation select encoding for the sub input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Default geometry for instantiating blocks.
    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_STAGES = 4;

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple adder slice: sum, carry-out and carry into the MSB.
module adder_slice
    import pipe_adder_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         cmsb
);

    // Full add; the carry into the MSB is recovered from the MSB sum bit.
    always_comb begin
        {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        cmsb    = s[W-1] ^ a[W-1] ^ b[W-1];
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: the WIDTH-bit carry chain is split into STAGES registered slices.
// Stage k adds slice k; higher slices ride along as operands (skew) and lower slices ride along
// as finished sum bits (deskew), so every stage register holds one whole operation.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder: STAGES must lie in 1..WIDTH and divide WIDTH");
    end

    localparam int unsigned SLICE = WIDTH / STAGES;

    // Stage registers: index k is the register at the output of stage k.
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] valid_q;
    logic              ovf_q;

    // Inputs seen by each stage (stage 0 from the ports, stage k from register k-1).
    logic [WIDTH-1:0]  stg_a   [STAGES];
    logic [WIDTH-1:0]  stg_b   [STAGES];
    logic [WIDTH-1:0]  stg_res [STAGES];
    logic [STAGES-1:0] stg_c;
    logic [STAGES-1:0] stg_v;

    // Slice adder results and next-state result words.
    logic [SLICE-1:0]  slc_s [STAGES];
    logic [STAGES-1:0] slc_co;
    logic [STAGES-1:0] slc_cm;
    logic [WIDTH-1:0]  res_d [STAGES];

    logic advance;

    // Global stall: everything moves only when the output slot is free or being drained.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Route stage inputs; SUB inverts b and the borrow so stage 0 always adds.
    always_comb begin
        stg_a[0]   = a;
        stg_b[0]   = b ^ {WIDTH{sub == OP_SUB}};
        stg_c[0]   = cin ^ (sub == OP_SUB);
        stg_v[0]   = in_valid;
        stg_res[0] = '0;
        for (int k = 1; k < int'(STAGES); k++) begin
            stg_a[k]   = opa_q[k-1];
            stg_b[k]   = opb_q[k-1];
            stg_c[k]   = carry_q[k-1];
            stg_v[k]   = valid_q[k-1];
            stg_res[k] = res_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .W (SLICE)
        ) u_slice (
            .a    (stg_a[k][k*SLICE +: SLICE]),
            .b    (stg_b[k][k*SLICE +: SLICE]),
            .ci   (stg_c[k]),
            .s    (slc_s[k]),
            .co   (slc_co[k]),
            .cmsb (slc_cm[k])
        );
    end

    // Merge each stage's freshly computed slice into the word it carries forward.
    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            res_d[k]                    = stg_res[k];
            res_d[k][k*SLICE +: SLICE]  = slc_s[k];
        end
    end

    // Pipeline registers: async clear, hold on stall, otherwise shift one stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                res_q[k] <= '0;
            end
            carry_q <= '0;
            valid_q <= '0;
            ovf_q   <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                opa_q[k] <= stg_a[k];
                opb_q[k] <= stg_b[k];
                res_q[k] <= res_d[k];
            end
            carry_q <= slc_co;
            valid_q <= stg_v;
            ovf_q   <= slc_cm[STAGES-1] ^ slc_co[STAGES-1];
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule
